// File: rtl/iter_multdiv.sv
`default_nettype none
// ============================================================================
// Module   : iter_multdiv
// Purpose  : Multi-cycle signed 32-bit multiply / divide unit for the execute
//            stage. Multiply is radix-4 Booth (16 iterations). Divide is
//            restoring division on operand magnitudes with a final sign fixup
//            (32 iterations).
//
// Ports    : clock          in   rising-edge clock
//            reset_n        in   synchronous, active-low reset
//            data_operandA  in   [31:0] multiplicand / dividend (signed)
//            data_operandB  in   [31:0] multiplier / divisor (signed)
//            ctrl_MULT      in   start-multiply pulse
//            ctrl_DIV       in   start-divide pulse (MULT wins if both)
//            data_result    out  [31:0] product low word or quotient
//            data_exception out  error flag, held alongside data_result
//            data_resultRDY out  one-cycle pulse, result valid
//            data_busy      out  operation in flight
//
// Options  : MULTDIV_MULT_OVF_EN - when defined, a multiply whose 64-bit
//            product does not fit in 32 signed bits raises data_exception.
//            When undefined the multiply exception is constant 0 and the
//            overflow detector is not built.
//
// Revision : 1.0  initial release
// ============================================================================
module iter_multdiv (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        data_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0]  C_MUL_LAST = 5'd15;
    localparam logic [4:0]  C_DIV_LAST = 5'd31;
    localparam logic [31:0] C_INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] C_NEG_ONE  = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t      state_q,  state_d;
    // Shared datapath register.
    //   MUL: {hi[32:0], lo[31:0], q_m1}
    //   DIV: {1'b0, R[31:0], Q[31:0], 1'b0}
    // Placing Q where the multiply low word lives lets both operations read
    // their result from acc_q[32:1].
    logic [65:0] acc_q,    acc_d;
    logic [31:0] mcand_q,  mcand_d;   // MUL: A,   DIV: |B|
    logic [4:0]  cnt_q,    cnt_d;
    logic        is_div_q, is_div_d;
    logic        sign_q,   sign_d;    // DIV: quotient must be negated
    logic        dexc_q,   dexc_d;    // DIV: exception decided at start
    logic        zero_q,   zero_d;    // DIV: divide by zero, force result 0
    logic [31:0] res_q,    res_d;
    logic        exc_q,    exc_d;
    logic        rdy_q,    rdy_d;

    logic        w_start;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;

    assign w_start = ctrl_MULT | ctrl_DIV;
    // Two's complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    assign w_abs_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    assign w_abs_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

    // ------------------------------------------------------------------------
    // Booth radix-4 step
    // ------------------------------------------------------------------------
    logic [34:0] w_a35;
    logic [34:0] w_addend;
    logic [34:0] w_sum;
    logic [67:0] w_mul_ext;
    logic [65:0] w_mul_next;

    assign w_a35 = {{3{mcand_q[31]}}, mcand_q};

    always_comb begin
        w_addend = 35'd0;
        case (acc_q[2:0])
            3'b001, 3'b010: w_addend = w_a35;
            3'b011:         w_addend = w_a35 << 1;
            3'b100:         w_addend = ~(w_a35 << 1) + 35'd1;
            3'b101, 3'b110: w_addend = ~w_a35 + 35'd1;
            default:        w_addend = 35'd0;
        endcase
    end

    // The upper part is widened to 35 bits for the add because hi + 2A can
    // briefly exceed the 33-bit range (e.g. A = -2^31). After the two-bit
    // shift the value fits back into 33 bits, so taking bits [67:2] of the
    // widened word is an exact arithmetic shift.
    assign w_sum      = {{2{acc_q[65]}}, acc_q[65:33]} + w_addend;
    assign w_mul_ext  = {w_sum, acc_q[32:0]};
    assign w_mul_next = w_mul_ext[67:2];

    // ------------------------------------------------------------------------
    // Restoring division step
    // ------------------------------------------------------------------------
    logic [31:0] w_rem;
    logic [31:0] w_quo;
    logic [33:0] w_trial;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [65:0] w_div_next;

    assign w_rem   = acc_q[64:33];
    assign w_quo   = acc_q[32:1];
    // Shifted remainder is 33 bits; one extra bit catches the borrow.
    assign w_trial = {1'b0, w_rem, w_quo[31]} - {2'b00, mcand_q};

    always_comb begin
        if (!w_trial[33]) begin
            w_rem_next = w_trial[31:0];
            w_quo_next = {w_quo[30:0], 1'b1};
        end else begin
            w_rem_next = {w_rem[30:0], w_quo[31]};
            w_quo_next = {w_quo[30:0], 1'b0};
        end
    end

    assign w_div_next = {1'b0, w_rem_next, w_quo_next, 1'b0};

    // ------------------------------------------------------------------------
    // Final result formation
    // ------------------------------------------------------------------------
    logic [31:0] w_div_res;
    logic        w_mul_exc;
    logic [31:0] w_fin_res;
    logic        w_fin_exc;

    assign w_div_res = zero_q ? 32'd0 : (sign_q ? (~w_quo + 32'd1) : w_quo);

`ifdef MULTDIV_MULT_OVF_EN
    // product[63:31] = {hi[31:0], lo[31]}; it fits in 32 signed bits only
    // when all of those bits agree.
    logic [32:0] w_ovf_bits;
    assign w_ovf_bits = {acc_q[64:33], acc_q[32]};
    assign w_mul_exc  = ~((&w_ovf_bits) | ~(|w_ovf_bits));
`else
    assign w_mul_exc  = 1'b0;
`endif

    assign w_fin_res = is_div_q ? w_div_res : acc_q[32:1];
    assign w_fin_exc = is_div_q ? dexc_q    : w_mul_exc;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sign_d   = sign_q;
        dexc_d   = dexc_q;
        zero_d   = zero_q;
        res_d    = res_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        // A start is honoured in every state, which aborts any operation in
        // flight and suppresses a result that would otherwise be reported.
        if (w_start) begin
            cnt_d = 5'd0;
            if (ctrl_MULT) begin
                state_d  = S_MUL;
                mcand_d  = data_operandA;
                acc_d    = {33'd0, data_operandB, 1'b0};
                is_div_d = 1'b0;
                sign_d   = 1'b0;
                dexc_d   = 1'b0;
                zero_d   = 1'b0;
            end else begin
                mcand_d  = w_abs_b;
                acc_d    = {33'd0, w_abs_a, 1'b0};
                is_div_d = 1'b1;
                sign_d   = data_operandA[31] ^ data_operandB[31];
                if (data_operandB == 32'd0) begin
                    state_d = S_DONE;
                    dexc_d  = 1'b1;
                    zero_d  = 1'b1;
                end else begin
                    state_d = S_DIV;
                    dexc_d  = (data_operandA == C_INT_MIN) &&
                              (data_operandB == C_NEG_ONE);
                    zero_d  = 1'b0;
                end
            end
        end else begin
            case (state_q)
                S_MUL: begin
                    acc_d = w_mul_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == C_MUL_LAST) begin
                        state_d = S_DONE;
                    end
                end
                S_DIV: begin
                    acc_d = w_div_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == C_DIV_LAST) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    res_d   = w_fin_res;
                    exc_d   = w_fin_exc;
                    rdy_d   = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            acc_q    <= 66'd0;
            mcand_q  <= 32'd0;
            cnt_q    <= 5'd0;
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            dexc_q   <= 1'b0;
            zero_q   <= 1'b0;
            res_q    <= 32'd0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sign_q   <= sign_d;
            dexc_q   <= dexc_d;
            zero_q   <= zero_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign data_busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_iter_multdiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_iter_multdiv
// Purpose  : Self-checking bench for iter_multdiv. Stimulus pushes expected
//            results (value, exception, RDY edge) into a scoreboard queue; a
//            monitor pops and compares on every data_resultRDY pulse.
// Revision : 1.0  initial release
// ============================================================================
module tb_iter_multdiv;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        data_busy;

`ifdef MULTDIV_MULT_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    iter_multdiv dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .data_busy      (data_busy)
    );

    always #5 clock = ~clock;

    // Number of rising edges so far; stable when sampled on the falling edge.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   op_id    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every RDY pulse must match the oldest outstanding expectation.
    exp_t mon_e;
    always @(negedge clock) begin
        if (data_resultRDY) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rdy: got RDY at edge %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("op%0d_result", mon_e.id), data_result, mon_e.res);
                chk($sformatf("op%0d_exception", mon_e.id), {31'd0, data_exception}, {31'd0, mon_e.exc});
                chk($sformatf("op%0d_rdy_edge", mon_e.id), cyc, mon_e.due);
            end
        end
    end

    // Called on a falling edge; the start is sampled on the next rising edge.
    task automatic start_op(input logic m, input logic d,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic ee,
                            input int n, input bit push);
        exp_t e;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        op_id++;
        if (push) begin
            e.res = er;
            e.exc = ee;
            e.due = cyc + 1 + n;
            e.id  = op_id;
            sb.push_back(e);
        end
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        // Operands need not be held after the start edge.
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Waits for RDY, counting busy cycles from the cycle after the start edge.
    task automatic wait_rdy(input int exp_busy);
        int nb;
        nb = 0;
        for (int i = 0; i < 200; i++) begin
            if (data_resultRDY) begin
                chk($sformatf("op%0d_busy_in_rdy", op_id), {31'd0, data_busy}, 32'd0);
                chk($sformatf("op%0d_busy_cycles", op_id), nb, exp_busy);
                return;
            end
            if (data_busy) nb++;
            @(negedge clock);
        end
        checks++;
        failures++;
        $display("FAIL op%0d_timeout: got no RDY within 200 cycles expected RDY", op_id);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset, including reset overriding a start --------
        repeat (3) @(negedge clock);
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        ctrl_MULT     = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        chk("reset_result", data_result, 32'd0);
        chk("reset_exception", {31'd0, data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset_busy", {31'd0, data_busy}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // ---------------- multiply ------------------------------------------
        start_op(1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 17, 1);
        wait_rdy(17);
        start_op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, OVF, 17, 1);
        wait_rdy(17);
        start_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, OVF, 17, 1);
        wait_rdy(17);
        start_op(1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, OVF, 17, 1);
        wait_rdy(17);
        start_op(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, OVF, 17, 1);
        wait_rdy(17);
        start_op(1, 0, 32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 1'b0, 17, 1);
        wait_rdy(17);
        start_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 17, 1);
        wait_rdy(17);

        // ---------------- divide --------------------------------------------
        start_op(0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, 1);
        wait_rdy(33);
        start_op(0, 1, 32'd100, 32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0, 33, 1);
        wait_rdy(33);
        start_op(0, 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 33, 1);
        wait_rdy(33);
        start_op(0, 1, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, 33, 1);
        wait_rdy(33);
        start_op(0, 1, 32'd0, 32'hFFFF_FFFB, 32'd0, 1'b0, 33, 1);
        wait_rdy(33);
        start_op(0, 1, 32'd3, 32'd5, 32'd0, 1'b0, 33, 1);
        wait_rdy(33);
        start_op(0, 1, 32'd5, 32'd0, 32'd0, 1'b1, 1, 1);
        wait_rdy(1);
        start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33, 1);
        wait_rdy(33);

        // ---------------- abort / priority cases ----------------------------
        // DIV restarts a multiply in progress; only the DIV reports.
        start_op(1, 0, 32'h1234, 32'd5, 32'd0, 1'b0, 17, 0);
        repeat (4) @(negedge clock);
        start_op(0, 1, 32'd9, 32'd3, 32'd3, 1'b0, 33, 1);
        wait_rdy(33);
        // Both start pulses: multiply wins.
        start_op(1, 1, 32'd6, 32'd2, 32'd12, 1'b0, 17, 1);
        wait_rdy(17);
        // Start on the edge that would enter DONE.
        start_op(1, 0, 32'd11, 32'd13, 32'd0, 1'b0, 17, 0);
        repeat (15) @(negedge clock);
        start_op(1, 0, 32'd2, 32'd3, 32'd6, 1'b0, 17, 1);
        wait_rdy(17);
        // Start on the edge that would report the result.
        start_op(1, 0, 32'd11, 32'd13, 32'd0, 1'b0, 17, 0);
        repeat (16) @(negedge clock);
        start_op(0, 1, 32'd20, 32'd4, 32'd5, 1'b0, 33, 1);
        wait_rdy(33);
        // Back-to-back: start in the RDY cycle.
        start_op(1, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30, 1'b0, 17, 1);
        wait_rdy(17);
        start_op(0, 1, 32'd7, 32'd7, 32'd1, 1'b0, 33, 1);
        wait_rdy(33);

        // ---------------- reset in the middle of a divide -------------------
        start_op(0, 1, 32'd100, 32'd7, 32'd14, 1'b0, 33, 0);
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        chk("midreset_result", data_result, 32'd0);
        chk("midreset_exception", {31'd0, data_exception}, 32'd0);
        chk("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("midreset_busy", {31'd0, data_busy}, 32'd0);
        repeat (40) @(negedge clock);
        start_op(1, 0, 32'd3, 32'd4, 32'd12, 1'b0, 17, 1);
        wait_rdy(17);

        repeat (5) @(negedge clock);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
